// File: rtl/alarm_pkg.sv
// Shared constants, state encoding and helpers for the alarm controller slice.
// Pure declarations: no latency, no flow control.
package alarm_pkg;

  localparam int STATE_W = 3;

  localparam logic [1:0] KS_OK    = 2'd0;
  localparam logic [1:0] KS_ERROR = 2'd2;
  localparam logic [1:0] KS_NOKEY = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4,
    ST_LOCKOUT     = 3'd5
  } state_e;

  function automatic logic is_armed(state_e s);
    return (s == ST_ARMED) || (s == ST_ENTRY_DELAY) || (s == ST_ALARM);
  endfunction

endpackage

// File: rtl/key_event_sync.sv
// Synchronises key-checker status, emits 1-cycle key_ok/key_err edges (2 clk after input change)
// and a registered 1-cycle checker reset strobe the cycle after each event; no backpressure.
module key_event_sync
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] key_status_i,
  output logic       key_ok_o,
  output logic       key_err_o,
  output logic       chk_rst_o
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;
  logic [1:0] prev_q;
  logic       chk_rst_q;

  // chk_rst_q resets high so the checker is held for the first cycle after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q    <= KS_NOKEY;
      sync_q    <= KS_NOKEY;
      prev_q    <= KS_NOKEY;
      chk_rst_q <= 1'b1;
    end else begin
      meta_q    <= key_status_i;
      sync_q    <= meta_q;
      prev_q    <= sync_q;
      chk_rst_q <= key_ok_o | key_err_o;
    end
  end

  assign key_ok_o  = (sync_q == KS_OK)    && (prev_q != KS_OK);
  assign key_err_o = (sync_q == KS_ERROR) && (prev_q != KS_ERROR);
  assign chk_rst_o = chk_rst_q;

endmodule

// File: rtl/alarm_controller.sv
// Arm/disarm/alarm sequencer: inputs act 3 clk after they change, outputs registered, no backpressure.
// Optional tamper input enabled by defining ALARM_TAMPER_EN.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int EXIT_DELAY_CYC  = 8,
  parameter int ENTRY_DELAY_CYC = 6,
  parameter int SIREN_CYC       = 12,
  parameter int LOCKOUT_CYC     = 10,
  parameter int MAX_TRIES       = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         key_status_i,
  input  logic               door_i,
  input  logic               motion_i,
`ifdef ALARM_TAMPER_EN
  input  logic               tamper_i,
`endif
  output logic               chk_rst_o,
  output logic [STATE_W-1:0] state_o,
  output logic               armed_o,
  output logic               siren_o,
  output logic [1:0]         fail_cnt_o
);

  localparam int         TIMER_W = 8;
  localparam logic [2:0] MAX_C   = 3'(MAX_TRIES);

  logic               key_ok;
  logic               key_err;
  logic [1:0]         door_q;
  logic [1:0]         motion_q;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         fail_q, fail_d;
  logic               armed_q;
  logic               siren_q;
  logic               key_ok_eff;
  logic               err_eff;
  logic               max_hit;
  logic               expired;
  logic [2:0]         fail_inc;

  key_event_sync u_key_sync (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_status_i (key_status_i),
    .key_ok_o     (key_ok),
    .key_err_o    (key_err),
    .chk_rst_o    (chk_rst_o)
  );

`ifdef ALARM_TAMPER_EN
  logic [1:0] tamper_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tamper_q <= '0;
    else          tamper_q <= {tamper_q[0], tamper_i};
  end
`endif

  // Loaded with N-1 so that expiry fires after exactly N cycles in the state.
  function automatic logic [TIMER_W-1:0] load_val(state_e s);
    case (s)
      ST_EXIT_DELAY:  return TIMER_W'(EXIT_DELAY_CYC - 1);
      ST_ENTRY_DELAY: return TIMER_W'(ENTRY_DELAY_CYC - 1);
      ST_ALARM:       return TIMER_W'(SIREN_CYC - 1);
      ST_LOCKOUT:     return TIMER_W'(LOCKOUT_CYC - 1);
      default:        return '0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    key_ok_eff = key_ok && (state_q != ST_LOCKOUT);
    err_eff    = key_err && (state_q != ST_ALARM) && (state_q != ST_LOCKOUT);
    fail_inc   = {1'b0, fail_q} + 3'd1;
    max_hit    = err_eff && (fail_inc >= MAX_C);
    expired    = (timer_q == '0);

    if (key_ok_eff)   fail_d = '0;
    else if (err_eff) fail_d = max_hit ? MAX_C[1:0] : fail_inc[1:0];

    case (state_q)
      ST_DISARMED: begin
        if (key_ok_eff)   state_d = ST_EXIT_DELAY;
        else if (max_hit) state_d = ST_LOCKOUT;
      end
      ST_EXIT_DELAY: begin
        if (key_ok_eff)   state_d = ST_DISARMED;
        else if (max_hit) state_d = ST_ALARM;
        else if (expired) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (key_ok_eff)       state_d = ST_DISARMED;
        else if (max_hit)     state_d = ST_ALARM;
        else if (motion_q[1]) state_d = ST_ALARM;
        else if (door_q[1])   state_d = ST_ENTRY_DELAY;
      end
      ST_ENTRY_DELAY: begin
        if (key_ok_eff)                           state_d = ST_DISARMED;
        else if (max_hit || motion_q[1] || expired) state_d = ST_ALARM;
      end
      ST_ALARM: begin
        if (key_ok_eff)   state_d = ST_DISARMED;
        else if (expired) state_d = ST_ARMED;
      end
      ST_LOCKOUT: begin
        if (expired) begin
          state_d = ST_DISARMED;
          fail_d  = '0;
        end
      end
      default: state_d = ST_DISARMED;
    endcase

`ifdef ALARM_TAMPER_EN
    if (tamper_q[1] && !key_ok_eff) state_d = ST_ALARM;
`endif

    if (state_d != state_q) timer_d = load_val(state_d);
`ifdef ALARM_TAMPER_EN
    else if (tamper_q[1] && state_d == ST_ALARM) timer_d = load_val(ST_ALARM);
`endif
    else if (!expired)      timer_d = timer_q - TIMER_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      door_q   <= '0;
      motion_q <= '0;
      state_q  <= ST_DISARMED;
      timer_q  <= '0;
      fail_q   <= '0;
      armed_q  <= 1'b0;
      siren_q  <= 1'b0;
    end else begin
      door_q   <= {door_q[0], door_i};
      motion_q <= {motion_q[0], motion_i};
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      armed_q  <= is_armed(state_d);
      siren_q  <= (state_d == ST_ALARM);
    end
  end

  assign state_o    = state_q;
  assign armed_o    = armed_q;
  assign siren_o    = siren_q;
  assign fail_cnt_o = fail_q;

endmodule
